// File: rtl/clock_debouncer_if.sv
// Board-side bundle for clock_debouncer: raw switch/button inputs in, slow clocks, ticks and debounced levels out.
// When BTN_PULSE_EN is defined the bundle also carries btnS_pulse/btnR_pulse.
interface clock_debouncer_if;
  logic [7:0] sw;
  logic       btnS;
  logic       btnR;
  logic       clk_1;
  logic       clk_2;
  logic       clk_5;
  logic       clk_100;
  logic       tick_1;
  logic       tick_2;
  logic       tick_5;
  logic       tick_100;
  logic [7:0] sw_db;
  logic       btnS_db;
  logic       btnR_db;
`ifdef BTN_PULSE_EN
  logic       btnS_pulse;
  logic       btnR_pulse;
`endif

  modport master (
    output sw, btnS, btnR,
    input  clk_1, clk_2, clk_5, clk_100,
    input  tick_1, tick_2, tick_5, tick_100,
    input  sw_db, btnS_db, btnR_db
`ifdef BTN_PULSE_EN
    , input btnS_pulse, btnR_pulse
`endif
  );

  modport slave (
    input  sw, btnS, btnR,
    output clk_1, clk_2, clk_5, clk_100,
    output tick_1, tick_2, tick_5, tick_100,
    output sw_db, btnS_db, btnR_db
`ifdef BTN_PULSE_EN
    , output btnS_pulse, btnR_pulse
`endif
  );
endinterface

// File: rtl/clock_debouncer.sv
// Front end of the encrypt/decrypt board: 1/2/5/100 Hz clocks plus ticks, and debounced sw/btnS/btnR.
// Define BTN_PULSE_EN to add one-cycle btnS_pulse/btnR_pulse outputs on debounced button presses.
module clock_debouncer #(
  parameter int CLK_HZ      = 100000000,
  parameter int SW_STABLE   = 1000000,
  parameter int BTN_SAMPLES = 3
) (
  input logic              msclk,
  input logic              rst,
  clock_debouncer_if.slave io
);

  localparam int NDIV    = 4;
  localparam int HALF [NDIV] = '{CLK_HZ / 2, CLK_HZ / 4, CLK_HZ / 10, CLK_HZ / 200};
  localparam int DCW     = $clog2(CLK_HZ / 2 + 1);
  localparam int SCW     = $clog2(SW_STABLE + 1);
  localparam int TICK100 = 3;

  logic [DCW-1:0]  div_cnt_q [NDIV];
  logic [DCW-1:0]  div_cnt_d [NDIV];
  logic [NDIV-1:0] div_clk_q, div_clk_d;
  logic [NDIV-1:0] div_tick_q, div_tick_d;

  // Each divider wraps on H-1; the tick is registered alongside the 0->1 toggle so both rise together.
  always_comb begin
    for (int i = 0; i < NDIV; i++) begin
      div_cnt_d[i]  = div_cnt_q[i] + DCW'(1);
      div_clk_d[i]  = div_clk_q[i];
      div_tick_d[i] = 1'b0;
      if (div_cnt_q[i] == DCW'(HALF[i] - 1)) begin
        div_cnt_d[i]  = '0;
        div_clk_d[i]  = ~div_clk_q[i];
        div_tick_d[i] = ~div_clk_q[i];
      end
    end
  end

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIV; i++) begin
        div_cnt_q[i] <= '0;
      end
      div_clk_q  <= '0;
      div_tick_q <= '0;
    end else begin
      for (int i = 0; i < NDIV; i++) begin
        div_cnt_q[i] <= div_cnt_d[i];
      end
      div_clk_q  <= div_clk_d;
      div_tick_q <= div_tick_d;
    end
  end

  // Bit layout of the synchronizer chain: [7:0] sw, [8] btnS, [9] btnR.
  logic [9:0] sync1_q, sync1_d;
  logic [9:0] sync2_q, sync2_d;
  logic [7:0] sw_sync;
  logic [1:0] btn_sync;

  always_comb begin
    sync1_d = {io.btnR, io.btnS, io.sw};
    sync2_d = sync1_q;
  end

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sw_sync  = sync2_q[7:0];
  assign btn_sync = sync2_q[9:8];

  logic [SCW-1:0] sw_cnt_q [8];
  logic [SCW-1:0] sw_cnt_d [8];
  logic [7:0]     sw_db_q, sw_db_d;

  // A bit only follows after SW_STABLE consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    sw_db_d = sw_db_q;
    for (int b = 0; b < 8; b++) begin
      sw_cnt_d[b] = '0;
      if (sw_sync[b] != sw_db_q[b]) begin
        if (sw_cnt_q[b] == SCW'(SW_STABLE - 1)) begin
          sw_db_d[b] = sw_sync[b];
        end else begin
          sw_cnt_d[b] = sw_cnt_q[b] + SCW'(1);
        end
      end
    end
  end

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 8; b++) begin
        sw_cnt_q[b] <= '0;
      end
      sw_db_q <= '0;
    end else begin
      for (int b = 0; b < 8; b++) begin
        sw_cnt_q[b] <= sw_cnt_d[b];
      end
      sw_db_q <= sw_db_d;
    end
  end

  logic [BTN_SAMPLES-1:0] btn_sh_q [2];
  logic [BTN_SAMPLES-1:0] btn_sh_d [2];
  logic [1:0]             btn_db_q, btn_db_d;

  // Buttons are sampled only at 100 Hz; the vote uses the freshly shifted history.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      btn_sh_d[k] = btn_sh_q[k];
      btn_db_d[k] = btn_db_q[k];
      if (div_tick_q[TICK100]) begin
        btn_sh_d[k] = (btn_sh_q[k] << 1) | BTN_SAMPLES'(btn_sync[k]);
        if (&btn_sh_d[k]) begin
          btn_db_d[k] = 1'b1;
        end else if (~|btn_sh_d[k]) begin
          btn_db_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      btn_sh_q[0] <= '0;
      btn_sh_q[1] <= '0;
      btn_db_q    <= '0;
    end else begin
      btn_sh_q[0] <= btn_sh_d[0];
      btn_sh_q[1] <= btn_sh_d[1];
      btn_db_q    <= btn_db_d;
    end
  end

`ifdef BTN_PULSE_EN
  logic [1:0] btn_db_dly_q, btn_db_dly_d;
  logic [1:0] btn_pulse_q, btn_pulse_d;

  // Pulse lands the cycle after the debounced level rises; releases are ignored.
  always_comb begin
    btn_db_dly_d = btn_db_q;
    btn_pulse_d  = btn_db_q & ~btn_db_dly_q;
  end

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      btn_db_dly_q <= '0;
      btn_pulse_q  <= '0;
    end else begin
      btn_db_dly_q <= btn_db_dly_d;
      btn_pulse_q  <= btn_pulse_d;
    end
  end

  assign io.btnS_pulse = btn_pulse_q[0];
  assign io.btnR_pulse = btn_pulse_q[1];
`endif

  assign io.clk_1    = div_clk_q[0];
  assign io.clk_2    = div_clk_q[1];
  assign io.clk_5    = div_clk_q[2];
  assign io.clk_100  = div_clk_q[3];
  assign io.tick_1   = div_tick_q[0];
  assign io.tick_2   = div_tick_q[1];
  assign io.tick_5   = div_tick_q[2];
  assign io.tick_100 = div_tick_q[3];
  assign io.sw_db    = sw_db_q;
  assign io.btnS_db  = btn_db_q[0];
  assign io.btnR_db  = btn_db_q[1];

endmodule

// File: tb/tb_clock_debouncer.sv
// Scoreboard bench for clock_debouncer: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares them; directed checks cover latency and asynchronous reset.
module tb_clock_debouncer;
  localparam int CLK_HZ      = 1000;
  localparam int SW_STABLE   = 16;
  localparam int BTN_SAMPLES = 3;
  localparam int FREQ [4]    = '{1, 2, 5, 100};

  typedef struct packed {
    logic [3:0] clks;
    logic [3:0] ticks;
    logic [7:0] sw_db;
    logic [1:0] btn_db;
    logic [1:0] pulse;
  } exp_t;

  logic msclk;
  logic rst;
  int   check_count = 0;
  int   pass_count  = 0;
  exp_t exp_q [$];

  int         model_n;
  logic [9:0] raw_hist [$];
  logic [7:0] sw_seen [$];
  logic       btnS_samp [$];
  logic       btnR_samp [$];
  logic [7:0] m_sw_db;
  logic [1:0] m_btn_db;
  logic [1:0] m_prev_db;
  logic [1:0] m_pulse;

  clock_debouncer_if dut_if ();

  clock_debouncer #(
    .CLK_HZ     (CLK_HZ),
    .SW_STABLE  (SW_STABLE),
    .BTN_SAMPLES(BTN_SAMPLES)
  ) dut (
    .msclk(msclk),
    .rst  (rst),
    .io   (dut_if)
  );

  initial msclk = 1'b0;
  always #5 msclk = ~msclk;

  function automatic int halfPeriod(int i);
    return CLK_HZ / (2 * FREQ[i]);
  endfunction

  // n = msclk edges since reset release; the divided clock is 1 in every odd half-period.
  function automatic logic clkAt(int n, int i);
    return ((n / halfPeriod(i)) % 2) == 1;
  endfunction

  function automatic logic tickAt(int n, int i);
    return (n % (2 * halfPeriod(i))) == halfPeriod(i);
  endfunction

  function automatic logic [3:0] actualClocks();
    return {dut_if.clk_100, dut_if.clk_5, dut_if.clk_2, dut_if.clk_1};
  endfunction

  function automatic logic [3:0] actualTicks();
    return {dut_if.tick_100, dut_if.tick_5, dut_if.tick_2, dut_if.tick_1};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] sw_v, input logic s_v, input logic r_v, input int cycles);
    dut_if.sw   = sw_v;
    dut_if.btnS = s_v;
    dut_if.btnR = r_v;
    repeat (cycles) @(negedge msclk);
  endtask

  task automatic modelReset();
    model_n = 0;
    raw_hist.delete();
    raw_hist.push_back(10'd0);
    raw_hist.push_back(10'd0);
    sw_seen.delete();
    btnS_samp.delete();
    btnR_samp.delete();
    for (int i = 0; i < BTN_SAMPLES; i++) begin
      btnS_samp.push_back(1'b0);
      btnR_samp.push_back(1'b0);
    end
    m_sw_db   = '0;
    m_btn_db  = '0;
    m_prev_db = '0;
    m_pulse   = '0;
  endtask

  task automatic modelStep();
    logic [9:0] synced;
    logic       sample_btn;
    logic [1:0] new_db;
    logic       differ;
    int         ones_s;
    int         ones_r;
    sample_btn = tickAt(model_n, 3);
    model_n++;
    raw_hist.push_back({dut_if.btnR, dut_if.btnS, dut_if.sw});
    synced = raw_hist.pop_front();

    // A switch bit follows once its last SW_STABLE synchronized samples all disagree with it.
    sw_seen.push_back(synced[7:0]);
    if (sw_seen.size() > SW_STABLE) void'(sw_seen.pop_front());
    if (sw_seen.size() == SW_STABLE) begin
      for (int b = 0; b < 8; b++) begin
        differ = 1'b1;
        foreach (sw_seen[k]) begin
          if (sw_seen[k][b] == m_sw_db[b]) differ = 1'b0;
        end
        if (differ) m_sw_db[b] = ~m_sw_db[b];
      end
    end

    new_db = m_btn_db;
    if (sample_btn) begin
      btnS_samp.push_back(synced[8]);
      void'(btnS_samp.pop_front());
      btnR_samp.push_back(synced[9]);
      void'(btnR_samp.pop_front());
      ones_s = 0;
      ones_r = 0;
      foreach (btnS_samp[k]) ones_s += int'(btnS_samp[k]);
      foreach (btnR_samp[k]) ones_r += int'(btnR_samp[k]);
      if (ones_s == BTN_SAMPLES) new_db[0] = 1'b1;
      if (ones_s == 0)           new_db[0] = 1'b0;
      if (ones_r == BTN_SAMPLES) new_db[1] = 1'b1;
      if (ones_r == 0)           new_db[1] = 1'b0;
    end
    m_pulse   = m_btn_db & ~m_prev_db;
    m_prev_db = m_btn_db;
    m_btn_db  = new_db;
  endtask

  task automatic pushExpected();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.clks[i]  = clkAt(model_n, i);
      e.ticks[i] = tickAt(model_n, i);
    end
    e.sw_db  = m_sw_db;
    e.btn_db = m_btn_db;
    e.pulse  = m_pulse;
    exp_q.push_back(e);
  endtask

  initial begin : refModel
    modelReset();
    forever begin
      @(posedge msclk);
      if (rst) modelReset();
      else     modelStep();
      pushExpected();
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge msclk);
      if (exp_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL scoreboard_underflow: got empty queue, expected an entry at time %0t", $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("clocks", 32'(actualClocks()), 32'(e.clks));
        checkOutput("ticks", 32'(actualTicks()), 32'(e.ticks));
        checkOutput("sw_db", 32'(dut_if.sw_db), 32'(e.sw_db));
        checkOutput("btn_db", 32'({dut_if.btnR_db, dut_if.btnS_db}), 32'(e.btn_db));
`ifdef BTN_PULSE_EN
        checkOutput("btn_pulse", 32'({dut_if.btnR_pulse, dut_if.btnS_pulse}), 32'(e.pulse));
`endif
      end
    end
  end

  initial begin : stimulus
    logic [7:0] sw_r;
    logic       s_r;
    logic       r_r;
    int         guard;
    rst         = 1'b0;
    dut_if.sw   = '0;
    dut_if.btnS = 1'b0;
    dut_if.btnR = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge msclk);
    rst = 1'b0;

    // Short sw[3] glitch must be swallowed; a held level appears 2+SW_STABLE edges later.
    applyStimulus(8'h08, 1'b0, 1'b0, 10);
    applyStimulus(8'h00, 1'b0, 1'b0, 20);
    checkOutput("sw_glitch_blocked", 32'(dut_if.sw_db), 32'h00);
    applyStimulus(8'h08, 1'b0, 1'b0, 2 + SW_STABLE - 1);
    checkOutput("sw3_latency_pre", 32'(dut_if.sw_db), 32'h00);
    applyStimulus(8'h08, 1'b0, 1'b0, 1);
    checkOutput("sw3_latency", 32'(dut_if.sw_db), 32'h08);
    applyStimulus(8'h00, 1'b0, 1'b0, 30);

    // btnS held with one 0 sample in the middle, then released; then both buttons together.
    applyStimulus(8'h00, 1'b1, 1'b0, 20);
    applyStimulus(8'h00, 1'b0, 1'b0, 10);
    applyStimulus(8'h00, 1'b1, 1'b0, 60);
    applyStimulus(8'h00, 1'b0, 1'b0, 60);
    applyStimulus(8'h00, 1'b1, 1'b1, 60);
    applyStimulus(8'h00, 1'b0, 1'b0, 60);

    sw_r = '0;
    s_r  = 1'b0;
    r_r  = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0)  sw_r ^= 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) s_r = ~s_r;
      if ($urandom_range(0, 39) == 0) r_r = ~r_r;
      applyStimulus(sw_r, s_r, r_r, 1);
    end

    // Reach a phase with clk_1 high and all switches qualified, then reset asynchronously.
    applyStimulus(8'hFF, 1'b0, 1'b0, 40);
    guard = 0;
    while (!((model_n % 1000) >= 600 && (model_n % 1000) < 900) && guard < 1200) begin
      applyStimulus(8'hFF, 1'b0, 1'b0, 1);
      guard++;
    end
    checkOutput("pre_reset_clk_1", 32'(dut_if.clk_1), 32'h1);
    checkOutput("pre_reset_sw_db", 32'(dut_if.sw_db), 32'hFF);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs",
                32'({actualClocks(), actualTicks(), dut_if.sw_db, dut_if.btnR_db, dut_if.btnS_db}), 32'h0);
`ifdef BTN_PULSE_EN
    checkOutput("async_reset_pulse", 32'({dut_if.btnR_pulse, dut_if.btnS_pulse}), 32'h0);
`endif
    repeat (2) @(negedge msclk);
    rst = 1'b0;
    applyStimulus(8'hFF, 1'b0, 1'b0, 2 + SW_STABLE - 1);
    checkOutput("requalify_pre", 32'(dut_if.sw_db), 32'h00);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1);
    checkOutput("requalify", 32'(dut_if.sw_db), 32'hFF);

`ifdef BTN_PULSE_EN
    begin
      int pulses;
      pulses = 0;
      dut_if.btnR = 1'b1;
      for (int c = 0; c < 120; c++) begin
        if (c == 60) dut_if.btnR = 1'b0;
        @(negedge msclk);
        if (dut_if.btnR_pulse === 1'b1) pulses++;
      end
      checkOutput("btnR_pulse_count", 32'(pulses), 32'd1);
    end
`else
    applyStimulus(8'hFF, 1'b0, 1'b1, 60);
    applyStimulus(8'hFF, 1'b0, 1'b0, 60);
`endif

    applyStimulus(8'h00, 1'b0, 1'b0, 5);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
